osc_clkgen_mc: RTL and testbench

//  Synthesizable multi-channel oscillator emulator for SoC/FPGA builds where the analog
//  32K/32M oscillators are absent. Each channel derives a square wave from clk with a

---
 rtl/osc_clkgen_mc.sv | 135 +++++++++++++
 tb/tb_osc_clkgen_mc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_clkgen_mc.sv
// Multi-channel oscillator emulator: per-channel square wave from clk
// with trim, start-up delay, clean stop and a ready flag.
module osc_clkgen_mc #(
    parameter int NCH     = 4,
    parameter int CW      = 7,
    parameter int CNTW    = 16,
    parameter int HBASE   = 1,
    parameter int STARTUP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*CW-1:0] cfg,
    output logic [NCH-1:0]    cko,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    rdy
);

    localparam int SW = ($clog2(STARTUP) > 0) ? $clog2(STARTUP) : 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_START,
        ST_RUN,
        ST_STOP
    } state_t;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t          st_q, st_d;
        logic [SW-1:0]   scnt_q, scnt_d;
        logic [CNTW-1:0] cnt_q, cnt_d;
        logic [CNTW-1:0] half_q, half_d;
        logic            cko_q, cko_d;
        logic            tick_q, tick_d;
        logic            rdy_q, rdy_d;
        logic [CNTW-1:0] trim;
        logic            wrap;

        assign trim = CNTW'(HBASE) + CNTW'(cfg[g*CW +: CW]);
        assign wrap = (cnt_q == half_q - 1'b1);

        // next-state: start-up count, phase counting, trim latch, clean stop
        always_comb begin
            st_d   = st_q;
            scnt_d = scnt_q;
            cnt_d  = cnt_q;
            half_d = half_q;
            cko_d  = cko_q;
            unique case (st_q)
                ST_OFF: begin
                    cko_d = 1'b0;
                    cnt_d = '0;
                    if (en[g]) begin
                        st_d   = ST_START;
                        scnt_d = '0;
                    end
                end
                ST_START: begin
                    if (!en[g]) begin
                        st_d = ST_OFF;
                    end else if (scnt_q == SW'(STARTUP - 1)) begin
                        st_d   = ST_RUN;
                        cnt_d  = '0;
                        half_d = trim;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wrap) begin
                        cnt_d = '0;
                        cko_d = ~cko_q;
                        // trim only takes effect at a falling toggle
                        if (cko_q) half_d = trim;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (!en[g]) begin
                        if (!cko_q) begin
                            st_d  = ST_OFF;
                            cnt_d = '0;
                            cko_d = 1'b0;
                        end else if (wrap) begin
                            st_d = ST_OFF;
                        end else begin
                            st_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (wrap) begin
                        cnt_d = '0;
                        cko_d = 1'b0;
                        st_d  = ST_OFF;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    st_d  = ST_OFF;
                    cnt_d = '0;
                    cko_d = 1'b0;
                end
            endcase
            tick_d = cko_d & ~cko_q;
            rdy_d  = (st_d == ST_RUN);
        end

        // channel state registers with synchronous reset
        always_ff @(posedge clk) begin
            if (reset) begin
                st_q   <= ST_OFF;
                scnt_q <= '0;
                cnt_q  <= '0;
                half_q <= '0;
                cko_q  <= 1'b0;
                tick_q <= 1'b0;
                rdy_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                scnt_q <= scnt_d;
                cnt_q  <= cnt_d;
                half_q <= half_d;
                cko_q  <= cko_d;
                tick_q <= tick_d;
                rdy_q  <= rdy_d;
            end
        end

        assign cko[g]  = cko_q;
        assign tick[g] = tick_q;
        assign rdy[g]  = rdy_q;
    end

endmodule

// File: tb/tb_osc_clkgen_mc.sv
// Bench for osc_clkgen_mc: directed scenarios plus random soak
// against a countdown-based behavioural model.
module tb_osc_clkgen_mc;

    localparam int NCH     = 4;
    localparam int CW      = 7;
    localparam int HBASE   = 1;
    localparam int STARTUP = 8;

    localparam int M_OFF   = 0;
    localparam int M_START = 1;
    localparam int M_RUN   = 2;
    localparam int M_STOP  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    en;
    logic [NCH*CW-1:0] cfg;
    logic [NCH-1:0]    cko;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    rdy;

    int checks   = 0;
    int failures = 0;

    int m_mode [NCH];
    int m_wait [NCH];
    int m_left [NCH];
    int m_len  [NCH];
    bit m_lvl  [NCH];
    bit m_tick [NCH];

    int ph_cnt [NCH];
    int ph_exp [NCH];
    bit ph_ok  [NCH];
    bit prv_cko[NCH];

    osc_clkgen_mc #(
        .NCH(NCH), .CW(CW), .CNTW(16), .HBASE(HBASE), .STARTUP(STARTUP)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .cfg(cfg),
        .cko(cko), .tick(tick), .rdy(rdy)
    );

    always #5 clk = ~clk;

    function automatic int cfg_of(input int i);
        return int'(cfg[i*CW +: CW]);
    endfunction

    task automatic set_cfg(input int ch, input int v);
        cfg[ch*CW +: CW] = CW'(v);
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference: one clock edge with the inputs currently applied
    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            bit old;
            m_tick[i] = 1'b0;
            old = m_lvl[i];
            if (reset) begin
                m_mode[i] = M_OFF;
                m_lvl[i]  = 1'b0;
                m_left[i] = 0;
                m_wait[i] = 0;
            end else if (m_mode[i] == M_OFF) begin
                if (en[i]) begin
                    m_mode[i] = M_START;
                    m_wait[i] = STARTUP;
                end
            end else if (m_mode[i] == M_START) begin
                if (!en[i]) begin
                    m_mode[i] = M_OFF;
                end else begin
                    m_wait[i]--;
                    if (m_wait[i] == 0) begin
                        m_mode[i] = M_RUN;
                        m_len[i]  = HBASE + cfg_of(i);
                        m_left[i] = m_len[i];
                        m_lvl[i]  = 1'b0;
                    end
                end
            end else if (m_mode[i] == M_RUN) begin
                if (!en[i] && !old) begin
                    m_mode[i] = M_OFF;
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_lvl[i] = !old;
                        if (old) m_len[i] = HBASE + cfg_of(i);
                        m_left[i] = m_len[i];
                    end
                    if (!en[i]) m_mode[i] = m_lvl[i] ? M_STOP : M_OFF;
                    m_tick[i] = !old && m_lvl[i];
                end
            end else begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_lvl[i]  = 1'b0;
                    m_mode[i] = M_OFF;
                end
            end
        end
    endtask

    // one clock: advance model, compare every channel, check phase lengths
    task automatic cyc();
        int prev_mode [NCH];
        @(posedge clk);
        for (int i = 0; i < NCH; i++) prev_mode[i] = m_mode[i];
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) begin
            logic [2:0] got, exp;
            got = {cko[i], tick[i], rdy[i]};
            exp = {m_lvl[i], m_tick[i], m_mode[i] == M_RUN};
            checks++;
            assert (got === exp) else begin
                failures++;
                $error("FAIL cyc ch%0d cko/tick/rdy got=%b exp=%b", i, got, exp);
            end
            ph_cnt[i]++;
            if (reset) begin
                ph_ok[i] = 1'b0;
            end else if (cko[i] !== prv_cko[i]) begin
                if (ph_ok[i]) check($sformatf("phase ch%0d", i), ph_cnt[i], ph_exp[i]);
                ph_cnt[i] = 0;
                ph_exp[i] = m_len[i];
                ph_ok[i]  = 1'b1;
            end
            if (prev_mode[i] != M_RUN && m_mode[i] == M_RUN) begin
                ph_cnt[i] = 0;
                ph_exp[i] = m_len[i];
                ph_ok[i]  = 1'b1;
            end
            if (m_mode[i] == M_OFF) ph_ok[i] = 1'b0;
            prv_cko[i] = cko[i];
        end
    endtask

    // count cycles until the chosen output of a channel matches
    task automatic wait_for(input int ch, input int kind, input int lim, output int n);
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < lim) begin
            cyc();
            n++;
            case (kind)
                0:       hit = (rdy[ch] === 1'b1);
                1:       hit = (tick[ch] === 1'b1);
                default: hit = (cko[ch] === 1'b0);
            endcase
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = M_OFF; m_wait[i] = 0; m_left[i] = 0; m_len[i] = 0;
            m_lvl[i] = 0; m_tick[i] = 0;
            ph_cnt[i] = 0; ph_exp[i] = 0; ph_ok[i] = 0; prv_cko[i] = 0;
        end
        reset = 1'b1;
        en    = '0;
        cfg   = '0;
        cyc();
        cyc();
        check("rst_cko", int'(cko), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_rdy", int'(rdy), 0);
        reset = 1'b0;
        cyc();

        // basic run: cfg=3 gives 4 high / 4 low
        set_cfg(0, 3);
        en[0] = 1'b1;
        wait_for(0, 0, 40, n); check("t1_rdy_lat", n, 9);
        wait_for(0, 1, 40, n); check("t1_tick_lat", n, 4);
        wait_for(0, 1, 40, n); check("t1_period_a", n, 8);
        wait_for(0, 1, 40, n); check("t1_period_b", n, 8);

        // trim change during high phase
        set_cfg(0, 0);
        wait_for(0, 2, 40, n); check("t2_high_kept", n, 4);
        wait_for(0, 1, 40, n); check("t2_low_new", n, 1);
        wait_for(0, 1, 40, n); check("t2_period_new", n, 2);
        set_cfg(0, 3);
        wait_for(0, 1, 40, n);
        wait_for(0, 1, 40, n); check("t2_period_back", n, 8);

        // clean stop from high phase
        en[0] = 1'b0;
        cyc();
        check("t3_rdy_drop", int'(rdy[0]), 0);
        check("t3_cko_held", int'(cko[0]), 1);
        wait_for(0, 2, 40, n); check("t3_high_rest", n, 3);
        repeat (3) cyc();

        // stop from low phase goes straight to OFF
        en[0] = 1'b1;
        wait_for(0, 0, 40, n); check("t3_rdy_lat2", n, 9);
        wait_for(0, 1, 40, n);
        wait_for(0, 2, 40, n);
        en[0] = 1'b0;
        cyc();
        check("t3_low_off_rdy", int'(rdy[0]), 0);
        check("t3_low_off_cko", int'(cko[0]), 0);

        // abort during start-up, then full restart
        en[0] = 1'b1;
        repeat (6) cyc();
        en[0] = 1'b0;
        repeat (4) cyc();
        en[0] = 1'b1;
        wait_for(0, 0, 40, n); check("t4_restart_lat", n, 9);
        en[0] = 1'b0;
        repeat (10) cyc();

        // four channels at once, then reset mid-run
        set_cfg(0, 0); set_cfg(1, 1); set_cfg(2, 2); set_cfg(3, 127);
        en = '1;
        wait_for(3, 0, 40, n); check("t5_rdy_lat", n, 9);
        check("t5_all_rdy", int'(rdy), 15);
        wait_for(2, 1, 40, n); check("t5_ch2_first", n, 3);
        wait_for(2, 1, 40, n); check("t5_ch2_period", n, 6);
        wait_for(3, 1, 400, n); check("t5_ch3_first", n, 119);
        wait_for(3, 1, 400, n); check("t5_ch3_period", n, 256);
        reset = 1'b1;
        cyc();
        check("t5_rst_cko", int'(cko), 0);
        check("t5_rst_tick", int'(tick), 0);
        check("t5_rst_rdy", int'(rdy), 0);
        en = '0;
        reset = 1'b0;
        repeat (12) cyc();
        check("t5_stay_off", int'(rdy), 0);

        // random soak
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0)
                set_cfg($urandom_range(0, NCH-1), ($urandom_range(0, 3) == 0) ?
                        int'($urandom_range(0, 127)) : int'($urandom_range(0, 6)));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
